// File: rtl/trig_pkg.sv
// Shared trigger-path definitions: FSM states and default pulse timing used by
// both the output pulse shaper and the far-end small_filter.
package trig_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      GAP  = 2'd2
   } trig_state_t;

   localparam int TRIG_WD       = 3;
   localparam int TRIG_PEND_WD  = 2;
   localparam int TRIG_HIGH_CYC = 7;
   localparam int TRIG_LOW_CYC  = 5;

   // small_filter accepts a level held for n cycles; tie it to the shortest phase we emit.
   localparam int TRIG_FILT_N     = (TRIG_HIGH_CYC < TRIG_LOW_CYC) ? TRIG_HIGH_CYC : TRIG_LOW_CYC;
   localparam int TRIG_FILT_BOUND = TRIG_HIGH_CYC + TRIG_LOW_CYC;

endpackage

// File: rtl/trig_pend_ctr.sv
// Saturating up/down counter of queued trigger requests with a sticky drop flag.
module trig_pend_ctr
   import trig_pkg::*;
#(
   parameter int PEND_WD = TRIG_PEND_WD
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               inc,
   input  logic               dec,
   input  logic               ovf_clr,
   output logic [PEND_WD-1:0] pending,
   output logic               ovf
);

   logic full_s;
   logic drop_s;

   assign full_s = (pending == {PEND_WD{1'b1}});
   assign drop_s = inc && !dec && full_s;

   // Queue depth and sticky overflow; a drop in the same cycle beats ovf_clr.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= {PEND_WD{1'b0}};
         ovf     <= 1'b0;
      end else begin
         case ({inc, dec})
            2'b10:   pending <= full_s ? pending : pending + PEND_WD'(1);
            2'b01:   pending <= pending - PEND_WD'(1);
            default: pending <= pending;
         endcase
         if (drop_s) begin
            ovf <= 1'b1;
         end else if (ovf_clr) begin
            ovf <= 1'b0;
         end else begin
            ovf <= ovf;
         end
      end
   end

endmodule

// File: rtl/trig_pulse_shaper.sv
// Shapes single-cycle requests into fixed-width trigger pulses with a guaranteed gap.
// Optional TRIG_PULSE_COUNT_EN adds a 16-bit emitted-pulse counter output.
module trig_pulse_shaper
   import trig_pkg::*;
#(
   parameter int WD       = TRIG_WD,
   parameter int HIGH_CYC = TRIG_HIGH_CYC,
   parameter int LOW_CYC  = TRIG_LOW_CYC,
   parameter int PEND_WD  = TRIG_PEND_WD
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req,
   input  logic               ovf_clr,
   output logic               data_out,
   output logic               data_edge,
   output logic               busy,
   output logic [PEND_WD-1:0] pending,
`ifdef TRIG_PULSE_COUNT_EN
   output logic [15:0]        pulse_count,
`endif
   output logic               ovf
);

   trig_state_t   state_r;
   logic [WD-1:0] timer_r;
   logic          data_out_d_r;
   logic          req_any_s;
   logic          launch_s;

   assign req_any_s = req || (pending != PEND_WD'(0));
   assign data_edge = data_out ^ data_out_d_r;
   assign busy      = (state_r != IDLE) || (pending != PEND_WD'(0));

   // A pulse starts from IDLE at once, or from GAP only once the low time is served.
   always_comb begin
      launch_s = 1'b0;
      case (state_r)
         IDLE:    launch_s = req_any_s;
         GAP:     launch_s = (timer_r == WD'(0)) && req_any_s;
         default: launch_s = 1'b0;
      endcase
   end

   trig_pend_ctr #(
      .PEND_WD (PEND_WD)
   ) u_pend (
      .clk     (clk),
      .rst     (rst),
      .inc     (req),
      .dec     (launch_s),
      .ovf_clr (ovf_clr),
      .pending (pending),
      .ovf     (ovf)
   );

   // Phase FSM with timer and registered pulse output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= IDLE;
         timer_r      <= WD'(0);
         data_out     <= 1'b0;
         data_out_d_r <= 1'b0;
      end else begin
         data_out_d_r <= data_out;
         case (state_r)
            IDLE: begin
               if (launch_s) begin
                  state_r  <= HIGH;
                  data_out <= 1'b1;
                  timer_r  <= WD'(HIGH_CYC - 1);
               end
            end
            HIGH: begin
               if (timer_r != WD'(0)) begin
                  timer_r <= timer_r - WD'(1);
               end else begin
                  state_r  <= GAP;
                  data_out <= 1'b0;
                  timer_r  <= WD'(LOW_CYC - 1);
               end
            end
            GAP: begin
               if (timer_r != WD'(0)) begin
                  timer_r <= timer_r - WD'(1);
               end else if (launch_s) begin
                  state_r  <= HIGH;
                  data_out <= 1'b1;
                  timer_r  <= WD'(HIGH_CYC - 1);
               end else begin
                  state_r <= IDLE;
               end
            end
            default: begin
               state_r  <= IDLE;
               data_out <= 1'b0;
               timer_r  <= WD'(0);
            end
         endcase
      end
   end

`ifdef TRIG_PULSE_COUNT_EN
   // Counts every pulse launch; ovf_clr also resets it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pulse_count <= 16'd0;
      end else if (ovf_clr) begin
         pulse_count <= 16'd0;
      end else if (launch_s) begin
         pulse_count <= pulse_count + 16'd1;
      end else begin
         pulse_count <= pulse_count;
      end
   end
`endif

endmodule

// File: doc/trig_pulse_shaper.md
Name: trig_pulse_shaper

Overview:
- Output-side counterpart to the I/O input filter. It drives a trigger/strobe line off-FPGA, for example the scope trigger around an AES round.
- Each single-cycle request becomes a clean pulse with a guaranteed minimum high width and minimum low gap, so the far-end input filter always accepts it.
- Requests that arrive while a pulse is in flight are queued in a saturating pending counter and replayed back-to-back.

Parameters:
WD, 3, width of the phase timer; requires HIGH_CYC and LOW_CYC <= 2^WD
HIGH_CYC, 7, exact high duration of every pulse, in clk cycles (>=1)
LOW_CYC, 5, exact minimum low duration after every pulse, in clk cycles (>=1)
PEND_WD, 2, width of the pending-request counter; maximum queued = 2^PEND_WD-1

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
req  input  1  single-cycle pulse request, sampled every rising edge
ovf_clr  input  1  clears the sticky overflow flag
data_out  output  1  shaped pulse, registered output
data_edge  output  1  high for one cycle after each data_out transition (data_out XOR registered copy of data_out)
busy  output  1  high when state is not IDLE or pending is non-zero
pending  output  PEND_WD  number of queued requests not yet emitted
ovf  output  1  sticky flag: a request was dropped because the queue was full

Behaviour:
- Reset is async and active-high; state goes to IDLE and it takes effect immediately, including mid-pulse.
- Reset values of all outputs and internal registers: data_out=0, registered data_out copy=0 (so data_edge=0), pending=0, ovf=0, timer=0, busy=0.
- FSM states are IDLE, HIGH, GAP.
- IDLE:
  - If req=1 or pending>0: go to HIGH, data_out<=1, timer<=HIGH_CYC-1.
  - A request is consumed as follows: when req=1, pending is unchanged (req consumed directly); otherwise pending-1.
- HIGH: while timer!=0, decrement it. When timer==0: go to GAP, data_out<=0, timer<=LOW_CYC-1.
- GAP: while timer!=0, decrement it. When timer==0:
  - If pending>0 or req=1: go to HIGH, data_out<=1, timer<=HIGH_CYC-1, and consume one request as in IDLE.
  - Otherwise go to IDLE.
- Latency: data_out rises on the same edge that samples req in IDLE, so it is visible one cycle after req.
- Pulse timing:
  - High lasts exactly HIGH_CYC cycles.
  - Low lasts at least LOW_CYC cycles.
  - Back-to-back period is exactly HIGH_CYC+LOW_CYC.
- Pending arithmetic, unsigned, width PEND_WD:
  - req with no launch: +1.
  - Launch without req: -1.
  - req together with a launch: net 0.
  - req in HIGH/GAP with pending==2^PEND_WD-1: request dropped, pending holds, ovf<=1.
- ovf priority: ovf_clr clears ovf, but a simultaneous overflow event wins and ovf stays 1.
- Requests arriving during HIGH or GAP never shorten or extend the current phase.
- The timer never wraps, because it is only decremented when non-zero.

Optional Feature:
- Macro: TRIG_PULSE_COUNT_EN.
- Defined:
  - Adds output pulse_count [15:0].
  - Increments on each IDLE/GAP->HIGH transition and wraps 0xFFFF->0.
  - Reset value 0; also cleared by ovf_clr.
- Undefined: no port and no counter logic; all other behaviour is identical.

Decomposition:
- Shared package trig_pkg holds:
  - the state enum (IDLE=2'd0, HIGH=2'd1, GAP=2'd2);
  - default constants TRIG_HIGH_CYC and TRIG_LOW_CYC.
  - small_filter's bound/n defaults derive from the same package so both ends agree.
- One natural sub-module: trig_pend_ctr, the saturating up/down pending counter with overflow flag. The FSM and timer stay in the top module.

Test Plan:
1. Single request (defaults), req=1 for one cycle at edge k -> data_out=1 from edge k to edge k+7, then 0 for >=5 cycles; data_edge pulses twice; busy falls after the gap.
2. Three reqs on consecutive cycles while IDLE -> three pulses, 7 high / 5 low, period 12; pending goes 0,1,2 then drains 1,0 at pulse starts.
3. Overflow (PEND_WD=2): 6 reqs in consecutive cycles, the first launching the pulse -> pending saturates at 3; the 5th and 6th set ovf; exactly 4 pulses total; ovf_clr=1 afterwards -> ovf=0.
4. req on the exact final GAP cycle with pending=0 -> HIGH entered on that edge with no IDLE cycle; pending stays 0.
5. Reset mid-HIGH at cycle 3 of the pulse, with pending=2 -> data_out, pending and busy go to 0 immediately; req after release yields a full 7-cycle pulse.
6. With TRIG_PULSE_COUNT_EN: 10 isolated reqs -> pulse_count=10; ovf_clr -> 0. Rebuild without the macro -> waveforms identical to the other tests.
